// File: rtl/pixel_stream_proc.sv
// pixel_stream_proc: 8-bit valid/ready pixel stream processor with pass-through,
// invert and 3x3 programmable convolution over two line buffers.
module pixel_stream_proc #(
    parameter int IMG_WIDTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pixel_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [1:0]  mode,
    input  logic [71:0] kernel,
    output logic [7:0]  pixel_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        status
);
    localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;

    logic [7:0]      lb1 [IMG_WIDTH];
    logic [7:0]      lb2 [IMG_WIDTH];
    logic [CW-1:0]   col;
    logic [1:0]      rows_seen;
    logic            en, acc, wrap;
    logic [8:0][7:0] win;
    logic            v1;
    logic [1:0]      m1;
    logic [71:0]     k1;
    logic [7:0]      top_new, mid_new, conv, result;
    logic [19:0]     sum;

    assign en        = ready_in || !valid_out;
    assign ready_out = en;
    assign acc       = en && valid_in;
    assign wrap      = col == CW'(IMG_WIDTH - 1);
    assign status    = rows_seen == 2'd2;
    // rows not yet received since reset read as zero; stale RAM is masked here
    assign top_new   = rows_seen == 2'd2 ? lb2[col] : 8'd0;
    assign mid_new   = rows_seen != 2'd0 ? lb1[col] : 8'd0;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++)
            sum = sum + 20'(win[i]) * 20'(k1[8*(8-i) +: 8]);
        conv   = |sum[19:11] ? 8'd255 : sum[10:3];
        result = m1 == 2'b01 ? ~win[8] : m1 == 2'b10 ? conv : win[8];
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[col] <= pixel_in;
            lb2[col] <= lb1[col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            rows_seen <= '0;
            v1        <= 1'b0;
            valid_out <= 1'b0;
            pixel_out <= '0;
            win       <= '0;
            m1        <= '0;
            k1        <= '0;
        end else if (en) begin
            v1        <= valid_in;
            valid_out <= v1;
            pixel_out <= result;
            if (valid_in) begin
                for (int r = 0; r < 3; r++) begin
                    win[3*r]   <= col == '0 ? 8'd0 : win[3*r+1];
                    win[3*r+1] <= col == '0 ? 8'd0 : win[3*r+2];
                end
                win[2]    <= top_new;
                win[5]    <= mid_new;
                win[8]    <= pixel_in;
                m1        <= mode;
                k1        <= kernel;
                col       <= wrap ? '0 : col + 1'b1;
                rows_seen <= wrap && rows_seen != 2'd2 ? rows_seen + 1'b1 : rows_seen;
            end
        end
    end
endmodule

// File: tb/tb_pixel_stream_proc.sv
// tb_pixel_stream_proc: scoreboard bench for pixel_stream_proc with an image-level reference model.
module tb_pixel_stream_proc;
    localparam int W = 4;

    logic        clk = 0, rst = 1;
    logic [7:0]  pixel_in = 0;
    logic        valid_in = 0, ready_in = 1;
    logic [1:0]  mode = 0;
    logic [71:0] kernel = '0;
    logic        ready_out, valid_out, status;
    logic [7:0]  pixel_out;

    pixel_stream_proc #(.IMG_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in), .ready_out(ready_out),
        .mode(mode), .kernel(kernel), .pixel_out(pixel_out), .valid_out(valid_out),
        .ready_in(ready_in), .status(status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] d; int t; } exp_t;
    exp_t sb[$];
    int   hist[$];
    int   checks = 0, errors = 0;
    int   last_stall = -100;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Image-level model: every accepted pixel since reset is at (n / W, n % W).
    function automatic int model(int p, logic [1:0] m, logic [71:0] k);
        int n, r, c, s, rr, cc, px;
        n = hist.size();
        hist.push_back(p);
        if (m == 2'b01) return 255 - p;
        if (m != 2'b10) return p;
        r = n / W;
        c = n % W;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            rr = r - (2 - i / 3);
            cc = c - (2 - i % 3);
            px = (rr < 0 || cc < 0) ? 0 : hist[rr * W + cc];
            s += int'(k[8*(8-i) +: 8]) * px;
        end
        return (s >> 3) > 255 ? 255 : (s >> 3);
    endfunction

    function automatic logic [71:0] rand_k();
        logic [71:0] k;
        for (int i = 0; i < 9; i++)
            k[8*i +: 8] = ($urandom % 2) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        return k;
    endfunction

    task automatic step(logic v, logic [7:0] p, logic [1:0] m, logic [71:0] k, logic r, output logic a);
        @(negedge clk);
        valid_in = v; pixel_in = p; mode = m; kernel = k; ready_in = r;
        #4;
        chk("status", status, int'(hist.size() >= 2 * W));
        a = valid_in && ready_out;
        if (a) sb.push_back('{8'(model(p, m, k)), cyc});
    endtask

    task automatic send(logic [7:0] p, logic [1:0] m, logic [71:0] k, int rpct);
        logic a;
        int   n = 0;
        do begin
            step(1'b1, p, m, k, $urandom_range(0, 99) < rpct, a);
            n++;
        end while (!a && n < 50);
        if (!a) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        logic a;
        for (int n = 0; n < 50 && sb.size() > 0; n++) step(1'b0, 8'd0, 2'd0, '0, 1'b1, a);
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; valid_in = 0; ready_in = 1;
        sb.delete();
        hist.delete();
        @(negedge clk);
        rst = 0;
        #4;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_status", status, 0);
        chk("rst_pixel_out", pixel_out, 0);
    endtask

    initial begin : monitor
        logic       have_prev = 0;
        logic [7:0] prev_d = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            #3;
            if (rst) have_prev = 0;
            else begin
                if (have_prev) begin
                    chk("hold_valid", valid_out, 1);
                    chk("hold_data", pixel_out, prev_d);
                end
                if (valid_out && !ready_in) chk("stall_ready_out", ready_out, 0);
                if (!ready_in) last_stall = cyc;
                if (valid_out && ready_in) begin
                    if (sb.size() == 0) chk("spurious_output", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("pixel_out", pixel_out, e.d);
                        if (last_stall < e.t) chk("latency", cyc - e.t, 2);
                    end
                end
                have_prev = valid_out && !ready_in;
                prev_d    = pixel_out;
            end
        end
    end

    initial begin
        logic a;
        do_reset();
        for (int i = 0; i < 256; i++) send(8'(i), 2'b00, '0, 100);
        send(8'd0, 2'b01, '0, 100);
        send(8'd1, 2'b01, '0, 100);
        send(8'd200, 2'b01, '0, 100);
        send(8'd255, 2'b01, '0, 100);
        drain();

        do_reset();
        for (int i = 0; i < 3 * W; i++) send(8'd8, 2'b10, {9{8'd1}}, 100);
        drain();

        do_reset();
        for (int i = 0; i < 4 * W; i++) send(8'd255, 2'b10, {9{8'hff}}, 100);
        drain();

        do_reset();
        for (int i = 0; i < 6; i++) send(8'(30 + i), 2'b00, '0, 100);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(90 + i), 2'b10, {9{8'd3}}, 1'b0, a);
        for (int i = 0; i < 6; i++) send(8'(60 + i), 2'b10, {9{8'd3}}, 100);
        drain();

        do_reset();
        for (int i = 0; i < 20; i++) send(8'(i + 50), i < 11 ? 2'b00 : 2'b01, '0, 100);
        drain();

        do_reset();
        for (int i = 0; i < 600; i++)
            step($urandom % 4 != 0, 8'($urandom), 2'($urandom), rand_k(), $urandom_range(0, 99) < 70, a);
        drain();

        for (int i = 0; i < 7; i++) send(8'($urandom), 2'b10, rand_k(), 100);
        do_reset();
        for (int i = 0; i < 10; i++) send(8'($urandom), 2'b10, rand_k(), 80);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
